// File: rtl/pigro_alu.sv
// Registered 32-bit signed ALU for the PIGRO execution stage: one operation per enabled cycle, latency 1.
// Optional multiplier on opcode 10 is built only when PIGRO_ALU_MUL_EN is defined.
module pigro_alu (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] data_a,
  input  logic signed [31:0] data_b,
  input  logic        [4:0]  opcode,
  input  logic               enable,
  output logic signed [31:0] data_out,
  output logic               overflow,
  output logic               error
);

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_LSH  = 5'd7;
  localparam logic [4:0] OP_RSH  = 5'd8;
  localparam logic [4:0] OP_ARSH = 5'd9;
`ifdef PIGRO_ALU_MUL_EN
  localparam logic [4:0] OP_MUL  = 5'd10;
`endif

  logic signed [31:0] sum;
  logic signed [31:0] diff;
  logic        [4:0]  shamt;
  logic               shamt_range_err;
  logic signed [31:0] next_data;
  logic               next_overflow;
  logic               next_error;

  assign sum             = data_a + data_b;
  assign diff            = data_a - data_b;
  assign shamt           = data_b[4:0];
  assign shamt_range_err = |data_b[31:5];

`ifdef PIGRO_ALU_MUL_EN
  logic signed [63:0] product;
  logic               product_ovf;

  assign product     = 64'(data_a) * 64'(data_b);
  // The product fits in 32 signed bits only if the upper half is pure sign extension.
  assign product_ovf = (product[63:32] != {32{product[31]}});
`endif

  always_comb begin
    next_data     = data_out;
    next_overflow = 1'b0;
    next_error    = 1'b0;
    case (opcode)
      OP_NOP: begin
        next_data = data_out;
      end
      OP_ADD: begin
        next_data     = sum;
        next_overflow = (data_a[31] == data_b[31]) && (sum[31] != data_a[31]);
      end
      OP_SUB: begin
        next_data     = diff;
        next_overflow = (data_a[31] != data_b[31]) && (diff[31] != data_a[31]);
      end
      OP_AND: next_data = data_a & data_b;
      OP_OR:  next_data = data_a | data_b;
      OP_XOR: next_data = data_a ^ data_b;
      OP_NOT: next_data = ~data_a;
      // Out-of-range shift amounts are flagged, but the result still uses the low 5 bits.
      OP_LSH: begin
        next_data  = data_a << shamt;
        next_error = shamt_range_err;
      end
      OP_RSH: begin
        next_data  = data_a >> shamt;
        next_error = shamt_range_err;
      end
      OP_ARSH: begin
        next_data  = data_a >>> shamt;
        next_error = shamt_range_err;
      end
`ifdef PIGRO_ALU_MUL_EN
      OP_MUL: begin
        next_data     = product[31:0];
        next_overflow = product_ovf;
      end
`endif
      default: begin
        next_data  = 32'sd0;
        next_error = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 32'sd0;
      overflow <= 1'b0;
      error    <= 1'b0;
    end else if (enable) begin
      data_out <= next_data;
      overflow <= next_overflow;
      error    <= next_error;
    end
  end

endmodule

// File: tb/tb_pigro_alu.sv
// Self-checking bench for pigro_alu: directed steps plus random operations checked against a reference model.
// Expected {error, overflow, data_out} words are queued at drive time and popped one cycle later.
module tb_pigro_alu;

  localparam int W = 34;

  logic               clk;
  logic               rst;
  logic signed [31:0] data_a;
  logic signed [31:0] data_b;
  logic        [4:0]  opcode;
  logic               enable;
  logic signed [31:0] data_out;
  logic               overflow;
  logic               error;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_state;
  int           checks;
  int           errors;

  pigro_alu dut (
    .clk      (clk),
    .rst      (rst),
    .data_a   (data_a),
    .data_b   (data_b),
    .opcode   (opcode),
    .enable   (enable),
    .data_out (data_out),
    .overflow (overflow),
    .error    (error)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {error, overflow, data} for one enabled, non-reset cycle.
  function automatic logic [W-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] op, input logic [W-1:0] prev);
    logic [31:0] r;
    logic        ovf;
    logic        err;
    logic signed [63:0] p;
    r   = 32'h0;
    ovf = 1'b0;
    err = 1'b0;
    case (op)
      5'd0: r = prev[31:0];
      5'd1: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd2: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd3: r = a & b;
      5'd4: r = a | b;
      5'd5: r = a ^ b;
      5'd6: r = ~a;
      5'd7: begin r = a << b[4:0]; err = (b[31:5] != 27'd0); end
      5'd8: begin r = a >> b[4:0]; err = (b[31:5] != 27'd0); end
      5'd9: begin r = $signed(a) >>> b[4:0]; err = (b[31:5] != 27'd0); end
`ifdef PIGRO_ALU_MUL_EN
      5'd10: begin
        p   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r   = p[31:0];
        ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end
`endif
      default: begin r = 32'h0; err = 1'b1; end
    endcase
    return {err, ovf, r};
  endfunction

  // Driver: apply one cycle of stimulus away from the active edge and queue its expected result.
  task automatic drive(input logic r, input logic en, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [W-1:0] exp);
    @(negedge clk);
    rst    = r;
    enable = en;
    opcode = op;
    data_a = a;
    data_b = b;
    exp_q.push_back(exp);
    model_state = exp;
  endtask

  // Scoreboard: after the edge, pop the oldest expectation and compare all three outputs.
  task automatic check(input string tag);
    logic [W-1:0] exp;
    logic [W-1:0] got;
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, {error, overflow, data_out});
      return;
    end
    exp = exp_q.pop_front();
    got = {error, overflow, data_out};
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed err=%b ovf=%b data=%h, expected err=%b ovf=%b data=%h",
             tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic en, input logic [4:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [W-1:0] exp);
    drive(r, en, op, a, b, exp);
    check(tag);
  endtask

  task automatic rand_step(input int idx);
    logic [31:0]  a;
    logic [31:0]  b;
    logic [4:0]   op;
    logic         en;
    logic [W-1:0] exp;
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
    op = 5'($urandom_range(0, 12));
    en = ($urandom_range(0, 4) != 0);
    exp = en ? model(a, b, op, model_state) : model_state;
    step($sformatf("rand%0d_op%0d", idx, op), 1'b0, en, op, a, b, exp);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    model_state = '0;
    rst    = 1'b1;
    enable = 1'b1;
    opcode = 5'd0;
    data_a = 32'h0;
    data_b = 32'h0;

    // Reset held for two cycles with random, enabled stimulus
    step("reset0", 1'b1, 1'b1, 5'($urandom_range(0, 31)), $urandom, $urandom, {2'b00, 32'h0});
    step("reset1", 1'b1, 1'b1, 5'($urandom_range(0, 31)), $urandom, $urandom, {2'b00, 32'h0});

    // Arithmetic and overflow boundaries
    step("add_ovf_pos", 1'b0, 1'b1, 5'd1, 32'h7FFF_FFFF, 32'h1,         {2'b01, 32'h8000_0000});
    step("sub_5_7",     1'b0, 1'b1, 5'd2, 32'd5,         32'd7,         {2'b00, 32'hFFFF_FFFE});
    step("add_ovf_neg", 1'b0, 1'b1, 5'd1, 32'h8000_0000, 32'hFFFF_FFFF, {2'b01, 32'h7FFF_FFFF});
    step("sub_ovf",     1'b0, 1'b1, 5'd2, 32'h8000_0000, 32'h1,         {2'b01, 32'h7FFF_FFFF});
    step("sub_no_ovf",  1'b0, 1'b1, 5'd2, 32'hFFFF_FFFF, 32'h7FFF_FFFF, {2'b00, 32'h8000_0000});

    // Shifts
    step("arsh_4",      1'b0, 1'b1, 5'd9, 32'h8000_0010, 32'd4,  {2'b00, 32'hF800_0001});
    step("rsh_4",       1'b0, 1'b1, 5'd8, 32'h8000_0010, 32'd4,  {2'b00, 32'h0800_0001});
    step("lsh_4",       1'b0, 1'b1, 5'd7, 32'h8000_0010, 32'd4,  {2'b00, 32'h0000_0100});
    step("lsh_32_err",  1'b0, 1'b1, 5'd7, 32'h8000_0010, 32'd32, {2'b10, 32'h8000_0010});
    step("arsh_31",     1'b0, 1'b1, 5'd9, 32'h8000_0000, 32'd31, {2'b00, 32'hFFFF_FFFF});

    // Hold, NOP and illegal opcode
    step("add_1234",    1'b0, 1'b1, 5'd1, 32'h1000, 32'h234, {2'b00, 32'h0000_1234});
    step("hold_en0",    1'b0, 1'b0, 5'd1, 32'd1,    32'd1,   {2'b00, 32'h0000_1234});
    step("nop",         1'b0, 1'b1, 5'd0, $urandom, $urandom, {2'b00, 32'h0000_1234});
    step("add_ovf_pre", 1'b0, 1'b1, 5'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, {2'b01, 32'hFFFF_FFFE});
    step("nop_clears",  1'b0, 1'b1, 5'd0, 32'd3,    32'd4,   {2'b00, 32'hFFFF_FFFE});
    step("illegal_20",  1'b0, 1'b1, 5'd20, 32'h55,  32'h66,  {2'b10, 32'h0});
    step("hold_err",    1'b0, 1'b0, 5'd3,  32'hFF,  32'hFF,  {2'b10, 32'h0});
    step("illegal_31",  1'b0, 1'b1, 5'd31, 32'h1,   32'h1,   {2'b10, 32'h0});

    // Logic
    step("and", 1'b0, 1'b1, 5'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, {2'b00, 32'h00F0_00F0});
    step("or",  1'b0, 1'b1, 5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, {2'b00, 32'hFFF0_FFF0});
    step("xor", 1'b0, 1'b1, 5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, {2'b00, 32'hFF00_FF00});
    step("not", 1'b0, 1'b1, 5'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, {2'b00, 32'h0F0F_0F0F});

    // Multiply (opcode 10)
`ifdef PIGRO_ALU_MUL_EN
    step("mul_neg",  1'b0, 1'b1, 5'd10, 32'hFFFF_FFFD, 32'd7,       {2'b00, 32'hFFFF_FFEB});
    step("mul_ovf",  1'b0, 1'b1, 5'd10, 32'h0001_0000, 32'h0001_0000, {2'b01, 32'h0});
`else
    step("mul_off_a", 1'b0, 1'b1, 5'd10, 32'hFFFF_FFFD, 32'd7,         {2'b10, 32'h0});
    step("mul_off_b", 1'b0, 1'b1, 5'd10, 32'h0001_0000, 32'h0001_0000, {2'b10, 32'h0});
`endif

    // Reset mid-stream discards the in-flight result
    step("pre_rst",   1'b0, 1'b1, 5'd1, 32'd100, 32'd23, {2'b00, 32'd123});
    step("mid_rst",   1'b1, 1'b1, 5'd1, 32'd100, 32'd23, {2'b00, 32'h0});
    step("post_rst",  1'b0, 1'b0, 5'd1, 32'd9,   32'd9,   {2'b00, 32'h0});

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) rand_step(i);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: observed %0d pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
